// File: rtl/lru_repl_ctrl_if.sv
// Request/response bus between the cache controller and the LRU age keeper.
// The master issues touch/victim/demote requests; the slave owns the ages.
interface lru_repl_ctrl_if #(
  parameter int SET_W = 4,
  parameter int WAY_W = 3
) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [SET_W-1:0] req_set;
  logic [WAY_W-1:0] req_way;
  logic             resp_valid;
  logic [WAY_W-1:0] resp_way;
  logic             resp_err;
  logic             init_busy;

  modport master (
    output req_valid, req_op, req_set, req_way,
    input  req_ready, resp_valid, resp_way, resp_err, init_busy
  );

  modport slave (
    input  req_valid, req_op, req_set, req_way,
    output req_ready, resp_valid, resp_way, resp_err, init_busy
  );
endinterface

// File: rtl/lru_repl_ctrl.sv
// True-LRU age keeper for a set-associative cache.
// One request at a time: IDLE accepts, READ fetches, UPDATE writes back.
module lru_repl_ctrl #(
  parameter int NUM_SETS = 16,
  parameter int WAYS     = 8,
  localparam int SET_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = $clog2(WAYS)
) (
  input logic clk,
  input logic rst_n,
  lru_repl_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_UPDATE
  } state_e;

  typedef logic [WAYS-1:0][WAY_W-1:0] vec_t;

  localparam logic [1:0] OP_VICTIM = 2'd1;
  localparam logic [1:0] OP_DEMOTE = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;
  localparam logic [WAY_W-1:0] AGE_LRU = WAY_W'(WAYS - 1);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);

  state_e           state_q, state_d;
  logic [SET_W-1:0] ptr_q, ptr_d;
  logic [1:0]       op_q, op_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] way_q, way_d;
  vec_t             work_q, work_d;
  logic [WAY_W-1:0] tgt_q, tgt_d;
  logic             rv_q, rv_d;
  logic [WAY_W-1:0] rway_q, rway_d;
  logic             rerr_q, rerr_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  vec_t             age_q [NUM_SETS];
  vec_t             age_d [NUM_SETS];

  vec_t             nxt_vec;
  logic             wrap;
  logic [WAY_W-1:0] tgt_age;

  // Promote (touch/victim) or retire (demote) the target within its set.
  always_comb begin
    nxt_vec = work_q;
    wrap    = 1'b0;
    tgt_age = work_q[tgt_q];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == tgt_q) begin
        nxt_vec[w] = (op_q == OP_DEMOTE) ? AGE_LRU : '0;
      end else if (op_q == OP_DEMOTE) begin
        if (work_q[w] > tgt_age) begin
          nxt_vec[w] = work_q[w] - 1'b1;
          wrap = wrap | (work_q[w] == '0);
        end
      end else if (work_q[w] < tgt_age) begin
        nxt_vec[w] = work_q[w] + 1'b1;
        wrap = wrap | (work_q[w] == AGE_LRU);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    set_d   = set_q;
    way_d   = way_q;
    work_d  = work_q;
    tgt_d   = tgt_q;
    rv_d    = 1'b0;
    rway_d  = rway_q;
    rerr_d  = rerr_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    age_d   = age_q;
    unique case (state_q)
      S_INIT: begin
        for (int w = 0; w < WAYS; w++) begin
          age_d[ptr_q][w] = WAY_W'(w);
        end
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_SET) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          set_d   = bus.req_set;
          way_d   = bus.req_way;
          state_d = S_READ;
          ready_d = 1'b0;
        end
      end
      S_READ: begin
        work_d = age_q[set_q];
        tgt_d  = way_q;
        if (op_q == OP_VICTIM) begin
          for (int w = 0; w < WAYS; w++) begin
            if (age_q[set_q][w] == AGE_LRU) begin
              tgt_d = WAY_W'(w);
            end
          end
        end
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        rv_d    = 1'b1;
        state_d = S_IDLE;
        ready_d = 1'b1;
        if (op_q == OP_RSVD) begin
          rway_d = '0;
          rerr_d = 1'b1;
        end else begin
          rway_d = tgt_q;
          rerr_d = 1'b0;
          age_d[set_q] = nxt_vec;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Ages carry no reset of their own; the INIT sweep rewrites them.
  always_ff @(posedge clk) begin
    age_q <= age_d;
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      op_q    <= '0;
      set_q   <= '0;
      way_q   <= '0;
      work_q  <= '0;
      tgt_q   <= '0;
      rv_q    <= 1'b0;
      rway_q  <= '0;
      rerr_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      set_q   <= set_d;
      way_q   <= way_d;
      work_q  <= work_d;
      tgt_q   <= tgt_d;
      rv_q    <= rv_d;
      rway_q  <= rway_d;
      rerr_q  <= rerr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_way   = rway_q;
  assign bus.resp_err   = rerr_q;
  assign bus.init_busy  = busy_q;

  a_no_wrap: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == S_UPDATE && op_q != OP_RSVD) |-> !wrap
  );

endmodule

// File: tb/tb_lru_repl_ctrl.sv
// Directed and random checks of lru_repl_ctrl against a recency-list model.
// Each set is modelled as an ordered list of ways, MRU first.
module tb_lru_repl_ctrl;
  localparam int NS = 4;
  localparam int NW = 4;
  localparam int SW = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lru_repl_ctrl_if #(.SET_W(SW), .WAY_W(WW)) bus ();

  lru_repl_ctrl #(.NUM_SETS(NS), .WAYS(NW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int lst [NS][$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(int s, int w);
    for (int i = 0; i < lst[s].size(); i++)
      if (lst[s][i] == w) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      lst[s].delete();
      for (int w = 0; w < NW; w++) lst[s].push_back(w);
    end
  endtask

  task automatic m_touch(int s, int w);
    lst[s].delete(idx_of(s, w));
    lst[s].push_front(w);
  endtask

  task automatic m_demote(int s, int w);
    lst[s].delete(idx_of(s, w));
    lst[s].push_back(w);
  endtask

  task automatic check_sets(string tag);
    for (int s = 0; s < NS; s++) begin
      logic [7:0] obs;
      logic [7:0] exp;
      logic [3:0] seen;
      obs  = dut.age_q[s];
      exp  = '0;
      seen = '0;
      for (int w = 0; w < NW; w++) begin
        exp[w*2 +: 2] = 2'(idx_of(s, w));
        seen[obs[w*2 +: 2]] = 1'b1;
      end
      chk($sformatf("%s_ages_s%0d", tag, s), 32'(obs), 32'(exp));
      chk($sformatf("%s_perm_s%0d", tag, s), 32'(seen), 32'hf);
    end
  endtask

  task automatic issue(logic [1:0] op, int s, int w, string tag);
    int n;
    int ew;
    logic ee;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(n < 100), 32'd1);
    ee = 1'b0;
    ew = w;
    case (op)
      2'd0: m_touch(s, w);
      2'd1: begin ew = lst[s][$]; m_touch(s, ew); end
      2'd2: m_demote(s, w);
      default: begin ew = 0; ee = 1'b1; end
    endcase
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_set   = 2'(s);
    bus.req_way   = 2'(w);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom_range(0, 3));
    bus.req_set   = 2'($urandom_range(0, 3));
    bus.req_way   = 2'($urandom_range(0, 3));
    chk({tag, "_rv_n1"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_rdy_n1"}, 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rv_n2"}, 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_rv"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_way"}, 32'(bus.resp_way), 32'(ew));
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(ee));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_hold"}, 32'(bus.resp_way), 32'(ew));
    check_sets(tag);
  endtask

  task automatic do_reset(string tag);
    int cnt;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk({tag, "_rv_rst"}, 32'(bus.resp_valid), 32'd0);
    end
    chk({tag, "_busy"}, 32'(bus.init_busy), 32'd1);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rway"}, 32'(bus.resp_way), 32'd0);
    chk({tag, "_rerr"}, 32'(bus.resp_err), 32'd0);
    rst_n = 1'b1;
    cnt = 0;
    while (bus.init_busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
      chk({tag, "_rv_init"}, 32'(bus.resp_valid), 32'd0);
    end
    chk({tag, "_busy_cycles"}, 32'(cnt), 32'd4);
    chk({tag, "_rdy_after"}, 32'(bus.req_ready), 32'd1);
    m_reset();
    check_sets({tag, "_id"});
  endtask

  initial begin
    int acc [$];
    int r;
    logic [1:0] op;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_set   = '0;
    bus.req_way   = '0;
    m_reset();
    @(negedge clk);
    do_reset("por");

    issue(2'd1, 0, 0, "vic1");
    chk("vic1_lit", 32'(bus.resp_way), 32'd3);
    issue(2'd1, 0, 0, "vic2");
    chk("vic2_lit", 32'(bus.resp_way), 32'd2);
    issue(2'd0, 0, 0, "touch0");
    issue(2'd1, 0, 0, "vic3");
    chk("vic3_lit", 32'(bus.resp_way), 32'd1);

    issue(2'd2, 1, 0, "dem0");
    issue(2'd1, 1, 0, "vic_s1");
    chk("vic_s1_lit", 32'(bus.resp_way), 32'd0);

    issue(2'd0, 0, lst[0][0], "touch_mru");
    issue(2'd2, 1, lst[1][$], "dem_lru");
    issue(2'd3, 2, 1, "rsvd");
    issue(2'd0, 2, 3, "s2_t");
    issue(2'd2, 2, 1, "s2_d");
    issue(2'd1, 2, 0, "s2_v");

    // Reset lands while the accepted request sits in READ.
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_set   = 2'd2;
    bus.req_way   = 2'(lst[2][$]);
    @(negedge clk);
    bus.req_valid = 1'b0;
    do_reset("midrst");

    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    bus.req_set   = 2'd3;
    bus.req_way   = 2'd2;
    for (int i = 0; i < 30; i++) begin
      if (bus.req_ready) begin
        acc.push_back(i);
        m_touch(3, 2);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_count", 32'(acc.size()), 32'd10);
    for (int i = 1; i < acc.size(); i++)
      chk("bp_gap", 32'(acc[i] - acc[i-1]), 32'd3);
    check_sets("bp");

    for (int i = 0; i < 10000; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue(op, $urandom_range(0, NS - 1), $urandom_range(0, NW - 1), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lru_repl_ctrl.md
Name: lru_repl_ctrl

Overview:
- Owns the true-LRU age state for every set of a set-associative cache.
- Serializes the cache controller's touch, victim and demote requests against that state, one request at a time.
- Returns the replacement way for misses.
- Sits between the cache tag/hit logic and the way-select mux; it is the only writer of the per-set age arrays.

Parameters:
- NUM_SETS, 16, number of sets tracked; must be a power of two, ≥2.
- WAYS, 8, associativity; must be a power of two, 2..16.
- SET_W, $clog2(NUM_SETS), set index width (derived, do not override).
- WAY_W, $clog2(WAYS), way index and age width (derived, do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  2  0=TOUCH, 1=VICTIM, 2=DEMOTE, 3=reserved.
- req_set  in  SET_W  target set.
- req_way  in  WAY_W  target way (TOUCH/DEMOTE); ignored for VICTIM.
- resp_valid  out  1  one-cycle completion pulse.
- resp_way  out  WAY_W  VICTIM: selected way; TOUCH/DEMOTE: echo of req_way.
- resp_err  out  1  high with resp_valid for reserved op.
- init_busy  out  1  high while the post-reset age sweep runs.

Behaviour:
- Storage: age[NUM_SETS][WAYS], each WAY_W bits. Age 0 = MRU, WAYS-1 = LRU.
- Invariant: outside INIT, each set's ages are a permutation of 0..WAYS-1.
- Reset (rst_n low at a clock edge):
  - All outputs 0 except init_busy=1.
  - FSM enters INIT; sweep pointer cleared.
  - Any in-flight request is dropped with no resp_valid.
- States:
  - INIT: each cycle writes set[ptr] with age[w]=w for all w, then ptr++. After writing set NUM_SETS-1 (NUM_SETS cycles total), go to IDLE and drop init_busy. req_ready=0 throughout.
  - IDLE: req_ready=1. On req_valid, capture op/set/way and go to READ. Otherwise stay.
  - READ: latch the addressed set's age vector into a working register. For VICTIM, select target way = the way whose age == WAYS-1. Go to UPDATE. req_ready=0.
  - UPDATE: write the modified vector back, pulse resp_valid with resp_way/resp_err, go to IDLE. req_ready=0.
- Latency and throughput:
  - Accept at cycle N; resp_valid at cycle N+2.
  - Next accept no earlier than N+3, so req_ready is high 1 cycle in 3 under back-to-back load.
- TOUCH(w):
  - Let a = age[w].
  - Every way with age < a increments.
  - age[w] becomes 0.
  - Ways with age > a are unchanged.
- VICTIM:
  - Target v = the way with age WAYS-1.
  - Apply TOUCH(v) and return resp_way=v; the victim becomes MRU because the caller fills it.
- DEMOTE(w), used for invalidation:
  - Let a = age[w].
  - Every way with age > a decrements.
  - age[w] becomes WAYS-1.
- Reserved op: no state change; resp_valid=1, resp_err=1, resp_way=0.
- Idempotent edges:
  - TOUCH on the current MRU leaves the set unchanged.
  - DEMOTE on the current LRU leaves the set unchanged.
  - Both still respond normally.
- Other sets are never modified by a request.
- Age arithmetic is WAY_W-bit unsigned. The permutation invariant guarantees no wrap; an assertion must flag any wrap.
- resp_way and resp_err hold their values until the next resp_valid or reset.
- req_* inputs are sampled only in IDLE with req_valid=1. Changes in other states are ignored.

Test Plan:
- Reset init, WAYS=4, NUM_SETS=4: hold rst_n low 2 cycles, release → init_busy high exactly 4 cycles, then req_ready=1. Every set reads ages {0,1,2,3} for ways 0..3.
- Victim sequence, set 0:
  - VICTIM → resp_way=3 at accept+2.
  - VICTIM → resp_way=2; ages now w0=2, w1=3, w2=0, w3=1.
- Touch then victim, continuing set 0:
  - TOUCH way0 → ages w0=0, w1=3, w2=1, w3=2.
  - VICTIM → resp_way=1.
- Demote, fresh set 1: DEMOTE way0 → ages w0=3, w1=0, w2=1, w3=2. VICTIM → resp_way=0.
- Edge and error cases:
  - TOUCH on the MRU way → ages unchanged, resp_valid pulse.
  - req_op=3 → resp_err=1, no set modified.
  - Requests to set 2 leave sets 0, 1 and 3 untouched.
- Reset mid-operation and backpressure:
  - Assert rst_n low during READ → no resp_valid; INIT reruns and all sets return to identity.
  - With req_valid held high continuously, exactly one accept every 3 cycles.
  - Random 10k-op run: permutation invariant holds on every set after every UPDATE.
